// File: rtl/Pipe_Buf_Reg_PKG.sv
// Pipeline buffer register types shared by the fetch stage and decode.
//   if_id_reg     : IF/ID register contents {Curr_Pc, Curr_Instr}
//   fetch_entry_t : one fetch-buffer / tag-queue entry {pc, instr}
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0)
package Pipe_Buf_Reg_PKG;

    localparam int unsigned PC_BITS   = 9;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [PC_BITS-1:0] Curr_Pc;
        logic [31:0]        Curr_Instr;
    } if_id_reg;

    typedef struct packed {
        logic [PC_BITS-1:0] pc;
        logic [31:0]        instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry FIFO of fetch_entry_t with synchronous clear.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clr        : empty the FIFO (wins over push/pop)
//   i_push/i_data: write an entry
//   i_pop        : drop the head entry
//   o_data       : head entry (meaningful only when o_count != 0)
//   o_count      : number of valid entries, 0..DEPTH
module fetch_buf
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  fetch_entry_t                 i_data,
    input  logic                         i_pop,
    output fetch_entry_t                 o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Guards keep the pointers sane even if a caller misbehaves.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: it is only read while r_count says it is valid.
    always_ff @(posedge clk) begin
        if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches to a handshaked
// variable-latency instruction memory, buffers the returned words and drives IF/ID.
//   clk, reset_n           : clock, asynchronous active-low reset
//   stall                  : hold IF/ID, do not pop the fetch buffer
//   redirect_valid/_pc     : EX-resolved taken branch/jump, flushes the stage
//   imem_req_valid/_addr   : fetch request (addr is word aligned)
//   imem_req_ready         : memory accepts the request
//   imem_rsp_valid/_data   : in-order read data, >= 1 cycle after acceptance
//   if_id, if_id_valid     : IF/ID register and its valid flag (0 = bubble)
module fetch_unit
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output if_id_reg        if_id,
    output logic            if_id_valid
);

    localparam int unsigned  CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] SLOTS = (CNT_W + 1)'(DEPTH);

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e           r_state;
    logic [PC_W-1:0]  r_fetch_pc;
    if_id_reg         r_if_id;
    logic             r_if_id_valid;

    logic [CNT_W-1:0] w_outstanding;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_out_after;
    logic [CNT_W:0]   w_inflight;
    fetch_entry_t     w_tag_in;
    fetch_entry_t     w_tag_head;
    fetch_entry_t     w_fifo_in;
    fetch_entry_t     w_fifo_head;
    logic             w_pop;
    logic             w_credit;
    logic             w_req_fire;
    logic             w_rsp_take;
    logic             w_push;
    logic             w_unused_tag_instr;

    assign w_pop = !stall && !redirect_valid && (w_count != '0);

    // Credit: buffered + in-flight never exceeds DEPTH, so every response has a slot.
    assign w_inflight = {1'b0, w_outstanding} + {1'b0, w_count};
    assign w_credit   = (w_inflight < SLOTS) || ((w_inflight == SLOTS) && w_pop);

    assign imem_req_valid = reset_n && (r_state == StFetch) && !redirect_valid && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are strays and are ignored.
    assign w_rsp_take  = imem_rsp_valid && (w_outstanding != '0);
    assign w_push      = w_rsp_take && (r_state == StFetch);
    assign w_out_after = w_outstanding - CNT_W'(w_rsp_take);

    // Tag queue: its occupancy is the outstanding-request count.
    assign w_tag_in = '{pc: PC_BITS'(r_fetch_pc), instr: '0};

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (1'b0),
        .i_push  (w_req_fire),
        .i_data  (w_tag_in),
        .i_pop   (w_rsp_take),
        .o_data  (w_tag_head),
        .o_count (w_outstanding)
    );

    assign w_unused_tag_instr = ^w_tag_head.instr;

    assign w_fifo_in = '{pc: w_tag_head.pc, instr: imem_rsp_data};

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_data_q (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StFetch;
            r_fetch_pc    <= '0;
            r_if_id       <= '{Curr_Pc: '0, Curr_Instr: NOP_INSTR};
            r_if_id_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= redirect_pc;
            r_state       <= (w_out_after != '0) ? StDrain : StFetch;
            r_if_id       <= '{Curr_Pc: '0, Curr_Instr: NOP_INSTR};
            r_if_id_valid <= 1'b0;
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_W'(4);
            if ((r_state == StDrain) && (w_out_after == '0)) r_state <= StFetch;
            if (!stall) begin
                if (w_count != '0) begin
                    r_if_id       <= '{Curr_Pc: w_fifo_head.pc, Curr_Instr: w_fifo_head.instr};
                    r_if_id_valid <= 1'b1;
                end else begin
                    r_if_id_valid <= 1'b0;
                end
            end
        end
    end

    assign if_id       = r_if_id;
    assign if_id_valid = r_if_id_valid;

endmodule
